// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational 16x16 multiplier,
// with an issue stage (S1) and a response stage (S2). Define MULT_ARB_SUM_MODE_EN to honour reqN_mode.
module mult_share_arbiter #(
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_a_sign,
  input  logic             req0_b_sign,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_a_sign,
  input  logic             req1_b_sign,
  input  logic             req1_mode,
  output logic [15:0]      m_a,
  output logic [15:0]      m_b,
  output logic             m_a_sign,
  output logic             m_b_sign,
  output logic [1:0]       m_mode,
  input  logic [31:0]      m_result_0,
  input  logic [31:0]      m_result_1,
  input  logic             m_result_SIDM_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [32:0]      rsp_result,
  output logic [CNT_W-1:0] issued_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid must not
  // wait on ready. reqN_ready is combinational from the grant; rsp_* hold while stalled.
  localparam logic LAST_INIT = (RR_INIT == 0) ? 1'b1 : 1'b0;

  logic        s1_valid;
  logic        s1_id;
  logic [15:0] s1_a;
  logic [15:0] s1_b;
  logic        s1_a_sign;
  logic        s1_b_sign;
  logic        s1_mode;
  logic        last_gnt;

  logic        adv1;
  logic        adv2;
  logic        gnt0;
  logic        gnt1;
  logic        xfer;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_a_sign;
  logic        in_b_sign;
  logic        in_mode;
  logic [31:0] sum32;
  logic [32:0] res_d;

  always_comb begin
    adv2 = s1_valid & (~rsp_valid | rsp_ready);
    adv1 = ~s1_valid | adv2;
    // On contention the requester that was not granted last wins.
    gnt0 = ~reset & adv1 & req0_valid & (~req1_valid | last_gnt);
    gnt1 = ~reset & adv1 & req1_valid & (~req0_valid | ~last_gnt);
    xfer = gnt0 | gnt1;
    in_a      = gnt1 ? req1_a      : req0_a;
    in_b      = gnt1 ? req1_b      : req0_b;
    in_a_sign = gnt1 ? req1_a_sign : req0_a_sign;
    in_b_sign = gnt1 ? req1_b_sign : req0_b_sign;
`ifdef MULT_ARB_SUM_MODE_EN
    in_mode   = gnt1 ? req1_mode   : req0_mode;
`else
    in_mode   = 1'b0;
`endif
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign m_a      = s1_valid ? s1_a : 16'h0000;
  assign m_b      = s1_valid ? s1_b : 16'h0000;
  assign m_a_sign = s1_valid & s1_a_sign;
  assign m_b_sign = s1_valid & s1_b_sign;

  always_comb begin
    sum32 = m_result_0 + m_result_1;
`ifdef MULT_ARB_SUM_MODE_EN
    // Sum mode folds the multiplier's SIDM carry in as bit 32 of the first partial.
    res_d  = s1_mode ? ({m_result_SIDM_carry, m_result_0} + {1'b0, m_result_1})
                     : {sum32[31], sum32};
    m_mode = s1_valid ? {1'b0, s1_mode} : 2'b00;
`else
    res_d  = {sum32[31], sum32};
    m_mode = 2'b00;
`endif
  end

`ifndef MULT_ARB_SUM_MODE_EN
  logic unused_mode;
  assign unused_mode = ^{req0_mode, req1_mode, m_result_SIDM_carry, s1_mode};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_a       <= 16'h0000;
      s1_b       <= 16'h0000;
      s1_a_sign  <= 1'b0;
      s1_b_sign  <= 1'b0;
      s1_mode    <= 1'b0;
      last_gnt   <= LAST_INIT;
      issued_cnt <= '0;
    end else if (xfer) begin
      s1_valid   <= 1'b1;
      s1_id      <= gnt1;
      s1_a       <= in_a;
      s1_b       <= in_b;
      s1_a_sign  <= in_a_sign;
      s1_b_sign  <= in_b_sign;
      s1_mode    <= in_mode;
      last_gnt   <= gnt1;
      issued_cnt <= issued_cnt + CNT_W'(1);
    end else if (adv2) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 33'h0;
    end else if (adv2) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= s1_id;
      rsp_result <= res_d;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
